// File: rtl/regfile_pkg.sv
// Shared types, default widths and the byte-merge helper for the register file bank.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned NREAD_DEF  = 2;

    // Widest register the merge helper handles; callers cast to their own width.
    localparam int unsigned MERGE_W = 256;
    localparam int unsigned MERGE_B = MERGE_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_e;

    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0] old_v,
        input logic [MERGE_W-1:0] new_v,
        input logic [MERGE_B-1:0] be
    );
        logic [MERGE_W-1:0] r;
        r = old_v;
        for (int unsigned i = 0; i < MERGE_B; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = new_v[8*i +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_scan.sv
// Scan engine: walks every register address once per request and streams it out
// over a valid/ready handshake, pulsing done after the last beat is accepted.
module regfile_scan
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start_i,
    input  logic              ready_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              done_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    scan_state_e       state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              valid_q;
    logic              done_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q <= SCAN;
                        ptr_q   <= '0;
                        valid_q <= 1'b1;
                    end
                end
                SCAN: begin
                    if (ready_i) begin
                        if (ptr_q == LAST_ADDR) begin
                            state_q <= DONE;
                            ptr_q   <= '0;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            ptr_q <= ptr_q + ADDR_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ptr_q   <= '0;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_addr_o = ptr_q;
    assign addr_o    = ptr_q;
    assign data_o    = rd_data_i;
    assign valid_o   = valid_q;
    assign done_o    = done_q;

endmodule

// File: rtl/regfile_bank.sv
// Multi-port register file with byte-merged write bypass on every read port,
// a pending-write scoreboard and a handshaked full-register scan stream.
module regfile_bank
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NREAD    = NREAD_DEF,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [DATA_W/8-1:0]       wen,
    input  logic [ADDR_W-1:0]         waddr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [NREAD-1:0]          ren,
    input  logic [NREAD*ADDR_W-1:0]   raddr,
    output logic [NREAD*DATA_W-1:0]   rdata,
    output logic [NREAD-1:0]          rvalid,
    input  logic                      busy_set,
    input  logic [ADDR_W-1:0]         busy_addr,
    output logic [(1<<ADDR_W)-1:0]    busy,
    input  logic                      scan_start,
    input  logic                      scan_ready,
    output logic                      scan_valid,
    output logic [ADDR_W-1:0]         scan_addr,
    output logic [DATA_W-1:0]         scan_data,
    output logic                      scan_done
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam bit          ZR    = (ZERO_REG != 0);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              wr_en_c;
    logic [DATA_W-1:0] wr_merged_c;
    logic [ADDR_W-1:0] scan_rd_addr;
    logic [DATA_W-1:0] scan_rd_data;

    // Writes to register 0 are dropped when it is hard-wired to zero.
    always_comb begin
        wr_en_c     = (|wen) && !(ZR && (waddr == '0));
        wr_merged_c = DATA_W'(byte_merge(MERGE_W'(mem_q[waddr]), MERGE_W'(wdata), MERGE_B'(wen)));
    end

    always_comb begin
        busy_d = busy_q;
        if (|wen) begin
            busy_d[waddr] = 1'b0;
        end
        if (busy_set) begin
            busy_d[busy_addr] = 1'b1;
        end
        if (ZR) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (wr_en_c) begin
                mem_q[waddr] <= wr_merged_c;
            end
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra_c;
        logic [DATA_W-1:0] rd_c;
        logic [DATA_W-1:0] rdata_q;
        logic              rvalid_q;

        // A same-cycle write to the read address is merged byte-wise into the result.
        always_comb begin
            ra_c = raddr[p*ADDR_W +: ADDR_W];
            rd_c = mem_q[ra_c];
            if (wr_en_c && (ra_c == waddr)) begin
                rd_c = DATA_W'(byte_merge(MERGE_W'(mem_q[ra_c]), MERGE_W'(wdata), MERGE_B'(wen)));
            end
            if (ZR && (ra_c == '0)) begin
                rd_c = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (!resetn) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= ren[p];
                if (ren[p]) begin
                    rdata_q <= rd_c;
                end
            end
        end

        assign rdata[p*DATA_W +: DATA_W] = rdata_q;
        assign rvalid[p]                 = rvalid_q;
    end

    always_comb begin
        scan_rd_data = mem_q[scan_rd_addr];
        if (ZR && (scan_rd_addr == '0)) begin
            scan_rd_data = '0;
        end
    end

    regfile_scan #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_scan (
        .clk       (clk),
        .resetn    (resetn),
        .start_i   (scan_start),
        .ready_i   (scan_ready),
        .rd_addr_o (scan_rd_addr),
        .rd_data_i (scan_rd_data),
        .valid_o   (scan_valid),
        .addr_o    (scan_addr),
        .data_o    (scan_data),
        .done_o    (scan_done)
    );

endmodule

// File: tb/tb_regfile_bank.sv
// Randomised and directed bench for regfile_bank, checked against a
// behavioural array model of storage, read ports and scoreboard.
module tb_regfile_bank;

    logic        clk;
    logic        resetn;
    logic [3:0]  wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  ren;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rvalid;
    logic        busy_set;
    logic [4:0]  busy_addr;
    logic [31:0] busy;
    logic        scan_start;
    logic        scan_ready;
    logic        scan_valid;
    logic [4:0]  scan_addr;
    logic [31:0] scan_data;
    logic        scan_done;

    logic [31:0] m_mem [32];
    logic [31:0] m_busy;
    logic [63:0] m_rdata;
    logic [1:0]  m_rvalid;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_bank #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .NREAD    (2),
        .ZERO_REG (1)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .wen        (wen),
        .waddr      (waddr),
        .wdata      (wdata),
        .ren        (ren),
        .raddr      (raddr),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .busy_set   (busy_set),
        .busy_addr  (busy_addr),
        .busy       (busy),
        .scan_start (scan_start),
        .scan_ready (scan_ready),
        .scan_valid (scan_valid),
        .scan_addr  (scan_addr),
        .scan_data  (scan_data),
        .scan_done  (scan_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic [31:0] mask);
        logic [31:0] v;
        v = m_mem[a];
        if (a == waddr) v = (v & ~mask) | (wdata & mask);
        if (a == 5'd0) v = 32'd0;
        return v;
    endfunction

    // Model the effect of one clock edge using the inputs currently applied.
    task automatic model_edge();
        logic [31:0] mask;
        if (!resetn) begin
            for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
            m_busy   = 32'd0;
            m_rdata  = 64'd0;
            m_rvalid = 2'b00;
            return;
        end
        mask = 32'd0;
        for (int i = 0; i < 4; i++) if (wen[i]) mask[8*i +: 8] = 8'hFF;
        for (int p = 0; p < 2; p++) begin
            if (ren[p]) m_rdata[32*p +: 32] = model_read(raddr[5*p +: 5], mask);
        end
        m_rvalid = ren;
        if (waddr != 5'd0) m_mem[waddr] = (m_mem[waddr] & ~mask) | (wdata & mask);
        if (wen != 4'd0) m_busy[waddr] = 1'b0;
        if (busy_set) m_busy[busy_addr] = 1'b1;
        m_busy[0] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("rdata", rdata, m_rdata);
        check("rvalid", 64'(rvalid), 64'(m_rvalid));
        check("busy", 64'(busy), 64'(m_busy));
    endtask

    task automatic idle_inputs();
        wen        = 4'd0;
        waddr      = 5'd0;
        wdata      = 32'd0;
        ren        = 2'b00;
        raddr      = 10'd0;
        busy_set   = 1'b0;
        busy_addr  = 5'd0;
        scan_start = 1'b0;
        scan_ready = 1'b0;
    endtask

    initial begin
        int k;
        int budget;
        bit tog;

        resetn = 1'b0;
        idle_inputs();
        tick();
        tick();
        check("rst_rdata", rdata, 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_scan_valid", 64'(scan_valid), 64'd0);
        check("rst_scan_addr", 64'(scan_addr), 64'd0);
        check("rst_scan_done", 64'(scan_done), 64'd0);
        resetn = 1'b1;
        tick();

        // Plain write then read on port 0.
        wen = 4'hF; waddr = 5'd5; wdata = 32'hDEADBEEF;
        tick();
        idle_inputs();
        ren = 2'b01; raddr = {5'd0, 5'd5};
        tick();
        check("read_deadbeef", 64'(rdata[31:0]), 64'h00000000DEADBEEF);
        check("read_rvalid0", 64'(rvalid[0]), 64'd1);
        idle_inputs();
        tick();
        check("rvalid_pulse", 64'(rvalid), 64'd0);
        check("rdata_hold", 64'(rdata[31:0]), 64'h00000000DEADBEEF);

        // Same-cycle partial write and read on port 1.
        wen = 4'b0011; waddr = 5'd5; wdata = 32'h00001234;
        ren = 2'b10; raddr = {5'd5, 5'd0};
        tick();
        check("bypass_merge", 64'(rdata[63:32]), 64'h00000000DEAD1234);
        idle_inputs();

        // Register 0 is hard-wired to zero and never busy.
        wen = 4'hF; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        ren = 2'b11; raddr = 10'd0; busy_set = 1'b1; busy_addr = 5'd0;
        tick();
        check("zero_bypass", rdata, 64'd0);
        check("zero_busy", 64'(busy[0]), 64'd0);
        idle_inputs();
        ren = 2'b11;
        tick();
        check("zero_read", rdata, 64'd0);
        idle_inputs();

        // Scoreboard set/clear priority.
        busy_set = 1'b1; busy_addr = 5'd7;
        tick();
        check("busy7_set", 64'(busy[7]), 64'd1);
        idle_inputs();
        wen = 4'h1; waddr = 5'd7; wdata = 32'h55; busy_set = 1'b1; busy_addr = 5'd7;
        tick();
        check("busy7_set_wins", 64'(busy[7]), 64'd1);
        idle_inputs();
        wen = 4'h1; waddr = 5'd7; wdata = 32'h66;
        tick();
        check("busy7_clear", 64'(busy[7]), 64'd0);
        idle_inputs();

        // Random traffic, read addresses often colliding with the write address.
        for (int i = 0; i < 300; i++) begin
            wen       = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
            waddr     = 5'($urandom);
            wdata     = $urandom;
            ren       = 2'($urandom);
            raddr[4:0] = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom);
            raddr[9:5] = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom);
            busy_set  = 1'($urandom);
            busy_addr = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
            tick();
        end
        idle_inputs();

        // Fill reg n with n*0x01010101 and scan with ready toggling.
        for (int n = 0; n < 32; n++) begin
            wen = 4'hF; waddr = 5'(n); wdata = n * 32'h01010101;
            tick();
        end
        idle_inputs();
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        check("scan_first_valid", 64'(scan_valid), 64'd1);
        k = 0; budget = 0; tog = 1'b1;
        while (k < 32 && budget < 200) begin
            check("scan_valid", 64'(scan_valid), 64'd1);
            check("scan_addr", 64'(scan_addr), 64'(k));
            check("scan_data", 64'(scan_data), 64'(k * 32'h01010101));
            check("scan_no_early_done", 64'(scan_done), 64'd0);
            scan_ready = tog;
            tick();
            if (tog) k++;
            tog = ~tog;
            budget++;
        end
        check("scan_beats", 64'(k), 64'd32);
        check("scan_done_pulse", 64'(scan_done), 64'd1);
        check("scan_valid_off", 64'(scan_valid), 64'd0);
        scan_ready = 1'b0;
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        check("scan_done_low", 64'(scan_done), 64'd0);
        check("scan_start_ignored_in_done", 64'(scan_valid), 64'd0);

        // Reset in the middle of a scan aborts without a done pulse.
        scan_start = 1'b1; scan_ready = 1'b1;
        tick();
        scan_start = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            check("abort_beat_addr", 64'(scan_addr), 64'(i));
            tick();
        end
        resetn = 1'b0; ren = 2'b11; raddr = {5'd3, 5'd9};
        tick();
        check("abort_valid", 64'(scan_valid), 64'd0);
        check("abort_done", 64'(scan_done), 64'd0);
        check("abort_addr", 64'(scan_addr), 64'd0);
        resetn = 1'b1; ren = 2'b00; scan_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_abort_done", 64'(scan_done), 64'd0);
            check("post_abort_valid", 64'(scan_valid), 64'd0);
        end

        // Restart with ready held high; random writes must show up in later beats.
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            check("rescan_valid", 64'(scan_valid), 64'd1);
            check("rescan_addr", 64'(scan_addr), 64'(c - 1));
            check("rescan_data", 64'(scan_data), 64'(m_mem[c - 1]));
            check("rescan_done", 64'(scan_done), 64'd0);
            wen = 4'($urandom); waddr = 5'($urandom); wdata = $urandom;
            tick();
        end
        idle_inputs();
        check("rescan_done_pulse", 64'(scan_done), 64'd1);
        check("rescan_valid_off", 64'(scan_valid), 64'd0);
        tick();
        check("rescan_done_low", 64'(scan_done), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
